// File: rtl/kernel_launcher_pkg.sv
// Shared GPU defines: host register map, STATUS bit layout and launcher state encoding.
package kernel_launcher_pkg;

    localparam logic [2:0] ADDR_CTRL            = 3'd0;
    localparam logic [2:0] ADDR_STATUS          = 3'd1;
    localparam logic [2:0] ADDR_BASE_INSTR      = 3'd2;
    localparam logic [2:0] ADDR_BASE_DATA       = 3'd3;
    localparam logic [2:0] ADDR_NUM_BLOCKS      = 3'd4;
    localparam logic [2:0] ADDR_WARPS_PER_BLOCK = 3'd5;
    localparam logic [2:0] ADDR_CYCLES          = 3'd6;
    localparam logic [2:0] ADDR_TIMEOUT         = 3'd7;

    localparam int CTRL_START_BIT   = 0;
    localparam int CTRL_ABORT_BIT   = 1;
    localparam int CTRL_IRQ_CLR_BIT = 2;

    localparam int STAT_BUSY_BIT    = 0;
    localparam int STAT_DONE_BIT    = 1;
    localparam int STAT_TIMEOUT_BIT = 2;
    localparam int STAT_ABORTED_BIT = 3;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_GPU_RST = 3'd1,
        ST_START   = 3'd2,
        ST_RUN     = 3'd3,
        ST_DONE    = 3'd4,
        ST_TIMEOUT = 3'd5
    } launch_state_t;

    function automatic logic [31:0] sat_inc(input logic [31:0] value);
        return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/kernel_launcher.sv
// Host-programmed GPU kernel launcher: register file, launch sequencing FSM,
// run-cycle counter with optional timeout, and sticky completion interrupt.
//
// state   | meaning
// IDLE    | no launch pending, waiting for CTRL.start
// GPU_RST | gpu_reset held high before the launch
// START   | one-cycle execution_start strobe
// RUN     | kernel executing, CYCLES counting
// DONE    | kernel reported execution_done
// TIMEOUT | CYCLES reached TIMEOUT, GPU being reset
module kernel_launcher
    import kernel_launcher_pkg::*;
#(
    parameter int unsigned GPU_RESET_CYCLES = 4,
    parameter logic [31:0] DEFAULT_TIMEOUT  = 32'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cfg_wr_en,
    input  logic        cfg_rd_en,
    input  logic [2:0]  cfg_addr,
    input  logic [31:0] cfg_wdata,
    output logic [31:0] cfg_rdata,
    output logic        cfg_rd_valid,
    output logic [31:0] base_instr,
    output logic [31:0] base_data,
    output logic [31:0] num_blocks,
    output logic [31:0] warps_per_block,
    output logic        execution_start,
    output logic        gpu_reset,
    input  logic        execution_done,
    output logic        irq
);

    localparam logic [7:0] RST_LOAD = 8'(GPU_RESET_CYCLES);

    launch_state_t state, state_next;
    logic [7:0]    rst_cnt;
    logic [31:0]   cycles_reg, timeout_reg, cycles_inc, status, rd_mux;
    logic          done_flag, timeout_flag, aborted_flag;
    logic          busy, ctrl_wr, start_req, abort_req, irq_clr_req, timeout_hit;
    logic          pulse_load, launch, enter_done, enter_timeout;

    assign busy        = (state == ST_GPU_RST) || (state == ST_START) || (state == ST_RUN);
    assign ctrl_wr     = cfg_wr_en && (cfg_addr == ADDR_CTRL);
    assign abort_req   = ctrl_wr && cfg_wdata[CTRL_ABORT_BIT];
    assign start_req   = ctrl_wr && cfg_wdata[CTRL_START_BIT] && !cfg_wdata[CTRL_ABORT_BIT];
    assign irq_clr_req = ctrl_wr && cfg_wdata[CTRL_IRQ_CLR_BIT];
    assign cycles_inc  = sat_inc(cycles_reg);
    // The current RUN cycle is counted before comparing, so CYCLES reads back equal to TIMEOUT.
    assign timeout_hit = (timeout_reg != 32'd0) && (cycles_inc == timeout_reg);

    assign execution_start = (state == ST_START);
    assign gpu_reset       = reset || (rst_cnt != 8'd0);

    always_comb begin
        status = 32'd0;
        status[STAT_BUSY_BIT]    = busy;
        status[STAT_DONE_BIT]    = done_flag;
        status[STAT_TIMEOUT_BIT] = timeout_flag;
        status[STAT_ABORTED_BIT] = aborted_flag;
    end

    always_comb begin
        state_next    = state;
        pulse_load    = 1'b0;
        launch        = 1'b0;
        enter_done    = 1'b0;
        enter_timeout = 1'b0;
        case (state)
            ST_IDLE, ST_DONE, ST_TIMEOUT: begin
                if (start_req) begin
                    state_next = ST_GPU_RST;
                    pulse_load = 1'b1;
                    launch     = 1'b1;
                end
            end
            ST_GPU_RST: begin
                if (abort_req) begin
                    state_next = ST_IDLE;
                    pulse_load = 1'b1;
                end else if (rst_cnt <= 8'd1) begin
                    state_next = ST_START;
                end
            end
            ST_START: begin
                if (abort_req) begin
                    state_next = ST_IDLE;
                    pulse_load = 1'b1;
                end else begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (abort_req) begin
                    state_next = ST_IDLE;
                    pulse_load = 1'b1;
                end else if (execution_done) begin
                    state_next = ST_DONE;
                    enter_done = 1'b1;
                end else if (timeout_hit) begin
                    state_next    = ST_TIMEOUT;
                    enter_timeout = 1'b1;
                    pulse_load    = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        rd_mux = 32'd0;
        case (cfg_addr)
            ADDR_STATUS:          rd_mux = status;
            ADDR_BASE_INSTR:      rd_mux = base_instr;
            ADDR_BASE_DATA:       rd_mux = base_data;
            ADDR_NUM_BLOCKS:      rd_mux = num_blocks;
            ADDR_WARPS_PER_BLOCK: rd_mux = warps_per_block;
            ADDR_CYCLES:          rd_mux = cycles_reg;
            ADDR_TIMEOUT:         rd_mux = timeout_reg;
            default:              rd_mux = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= ST_IDLE;
            rst_cnt         <= RST_LOAD;
            cycles_reg      <= 32'd0;
            timeout_reg     <= DEFAULT_TIMEOUT;
            base_instr      <= 32'd0;
            base_data       <= 32'd0;
            num_blocks      <= 32'd0;
            warps_per_block <= 32'd0;
            done_flag       <= 1'b0;
            timeout_flag    <= 1'b0;
            aborted_flag    <= 1'b0;
            irq             <= 1'b0;
            cfg_rdata       <= 32'd0;
            cfg_rd_valid    <= 1'b0;
        end else begin
            state <= state_next;

            if (pulse_load)
                rst_cnt <= RST_LOAD;
            else if (rst_cnt != 8'd0)
                rst_cnt <= rst_cnt - 8'd1;

            if (launch)
                cycles_reg <= 32'd0;
            else if (state == ST_RUN)
                cycles_reg <= cycles_inc;

            if (launch) begin
                done_flag    <= 1'b0;
                timeout_flag <= 1'b0;
                aborted_flag <= 1'b0;
            end else begin
                if (enter_done)
                    done_flag <= 1'b1;
                if (enter_timeout)
                    timeout_flag <= 1'b1;
                if (busy && abort_req)
                    aborted_flag <= 1'b1;
            end

            if (enter_done || enter_timeout)
                irq <= 1'b1;
            else if (irq_clr_req)
                irq <= 1'b0;

            if (cfg_wr_en && !busy) begin
                case (cfg_addr)
                    ADDR_BASE_INSTR:      base_instr      <= cfg_wdata;
                    ADDR_BASE_DATA:       base_data       <= cfg_wdata;
                    ADDR_NUM_BLOCKS:      num_blocks      <= cfg_wdata;
                    ADDR_WARPS_PER_BLOCK: warps_per_block <= cfg_wdata;
                    ADDR_TIMEOUT:         timeout_reg     <= cfg_wdata;
                    default: ;
                endcase
            end

            cfg_rd_valid <= cfg_rd_en;
            if (cfg_rd_en)
                cfg_rdata <= rd_mux;
        end
    end

endmodule
